uart_rx_os16: RTL

16x-oversampling UART receiver sitting directly upstream of the receive FIFO: it recovers 8-bit frames (start, 8 data LSB-first, optional parity, 1 stop) from the asynchronous `rx` line and presents each byte on a valid/ready interface that the FIFO write side consumes. Mid-bit sampling is derived from a single system clock, so no separate baud clock is required. Per-byte parity and framing errors travel with the data, and a lost-byte condition is flagged.

---
 rtl/uart_rx_os16_pkg.sv | 20 ++
 rtl/uart_os_tick.sv | 36 +++
 rtl/uart_rx_os16.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_rx_os16_pkg.sv
// uart_rx_os16_pkg
// Shared definitions for the oversampling UART receiver: receiver state
// encodings and frame/oversampling constants.
package uart_rx_os16_pkg;

    typedef enum logic [2:0] {
        IDLE_S  = 3'd0,
        START_S = 3'd1,
        DATA_S  = 3'd2,
        PRITY_S = 3'd3,
        STOP_S  = 3'd4
    } rx_state_t;

    localparam int         FRAME_DATA_BITS = 8;
    // Tick index (0-based) at the middle of the start bit.
    localparam logic [3:0] MID_TICK        = 4'd7;
    // Tick index (0-based) that closes a full 16-tick bit period.
    localparam logic [3:0] LAST_TICK       = 4'd15;

endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick
// Oversample tick generator: counts 0..OS_DIV-1 on the system clock and
// asserts o_tick while the count sits at OS_DIV-1.
// Ports:
//   i_clk  system clock
//   i_rst  synchronous active-high reset
//   i_clr  restart the count at 0 (phase-aligns ticks to a detected edge)
//   o_tick one-cycle oversample tick
module uart_os_tick #(
    parameter int OS_DIV = 27
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (OS_DIV > 2) ? $clog2(OS_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(OS_DIV - 1));
    assign o_tick = w_last;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_os16.sv
// uart_rx_os16
// 16x-oversampling UART receiver (start, 8 data LSB-first, optional parity,
// 1 stop). Each received byte is offered on a valid/ready interface together
// with its parity and framing error flags; a frame that completes while the
// previous byte is still unaccepted is dropped and reported on o_overrun.
// Ports:
//   i_clk, i_rst    system clock, synchronous active-high reset
//   i_rx            asynchronous serial line, idle high
//   o_data          received byte, stable while o_valid
//   o_valid/i_ready byte handshake, transfer on o_valid && i_ready
//   o_parity_err    parity mismatch for o_data (qualified by o_valid)
//   o_frame_err     stop bit sampled low for o_data (qualified by o_valid)
//   o_overrun       one-cycle pulse when a completed frame is dropped
module uart_rx_os16
    import uart_rx_os16_pkg::*;
#(
    parameter int OS_DIV     = 27,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_overrun
);

    logic      r_sync1, r_sync2, r_prev;
    rx_state_t r_state;
    logic [3:0] r_scnt;
    logic [2:0] r_bcnt;
    logic [7:0] r_shift;
    logic       r_perr;

    logic w_rx, w_fall, w_tick, w_clr, w_bit_end, w_can_load;

    assign w_rx       = r_sync2;
    assign w_fall     = r_prev & ~r_sync2;
    // Restart the tick phase on the same edge that enters START.
    assign w_clr      = (r_state == IDLE_S) && w_fall;
    assign w_bit_end  = w_tick && (r_scnt == LAST_TICK);
    // A slot is free if empty or being emptied this very cycle.
    assign w_can_load = !o_valid || i_ready;

    uart_os_tick #(.OS_DIV(OS_DIV)) u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    // Two-flop synchronizer plus a history flop for falling-edge detection.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE_S;
            r_scnt       <= 4'd0;
            r_bcnt       <= 3'd0;
            r_shift      <= 8'd0;
            r_perr       <= 1'b0;
            o_data       <= 8'd0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            if (w_tick) begin
                r_scnt <= r_scnt + 4'd1;
            end

            case (r_state)
                IDLE_S: begin
                    if (w_fall) begin
                        r_state <= START_S;
                        r_scnt  <= 4'd0;
                        r_bcnt  <= 3'd0;
                        r_perr  <= 1'b0;
                    end
                end
                START_S: begin
                    // Mid start bit: a high line here was a glitch.
                    if (w_tick && r_scnt == MID_TICK) begin
                        r_scnt  <= 4'd0;
                        r_state <= w_rx ? IDLE_S : DATA_S;
                    end
                end
                DATA_S: begin
                    if (w_bit_end) begin
                        r_shift <= {w_rx, r_shift[7:1]};
                        r_bcnt  <= r_bcnt + 3'd1;
                        if (r_bcnt == 3'(FRAME_DATA_BITS - 1)) begin
                            r_state <= (PARITY_EN != 0) ? PRITY_S : STOP_S;
                        end
                    end
                end
                PRITY_S: begin
                    if (w_bit_end) begin
                        r_perr  <= (^r_shift) ^ w_rx ^ 1'(PARITY_ODD);
                        r_state <= STOP_S;
                    end
                end
                STOP_S: begin
                    if (w_bit_end) begin
                        r_state <= IDLE_S;
                        if (w_can_load) begin
                            o_data       <= r_shift;
                            o_parity_err <= r_perr;
                            o_frame_err  <= ~w_rx;
                            o_valid      <= 1'b1;
                        end else begin
                            o_overrun <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE_S;
            endcase
        end
    end

endmodule
